// File: rtl/oc_bank_read_scheduler.sv
// Per-bank read scheduler: queues operand-collector read requests, issues one
// synchronous bank read per cycle, and returns row data tagged with its slot id.
module oc_bank_read_scheduler #(
  parameter int DEPTH  = 4,
  parameter int ROW_W  = 3,
  parameter int DATA_W = 256,
  parameter int OCID_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0_vld,
  input  logic [OCID_W-1:0]         push0_ocid,
  input  logic [ROW_W-1:0]          push0_row,
  input  logic                      push1_vld,
  input  logic [OCID_W-1:0]         push1_ocid,
  input  logic [ROW_W-1:0]          push1_row,
  output logic                      push_rdy,
  input  logic                      wb_we,
  input  logic [ROW_W-1:0]          wb_row,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic [7:0]                wb_mask,
  output logic                      rf_we,
  output logic [ROW_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [7:0]                rf_wmask,
  output logic                      rf_re,
  output logic [ROW_W-1:0]          rf_raddr,
  input  logic [DATA_W-1:0]         rf_rdata,
  output logic [DATA_W-1:0]         bk_data,
  output logic [OCID_W-1:0]         bk_ocid,
  output logic                      bk_vld,
  output logic                      bk_bz,
  output logic [$clog2(DEPTH):0]    q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OCID_W-1:0] ocid;
    logic [ROW_W-1:0]  row;
  } entry_t;

  entry_t            queue_mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push0;
  logic              do_push1;
  logic [1:0]        push_n;
  logic              pop;

  // Writeback owns the bank port unconditionally; it is a pure pass-through.
  assign rf_we    = wb_we;
  assign rf_waddr = wb_row;
  assign rf_wdata = wb_data;
  assign rf_wmask = wb_mask;

  // Readiness depends only on registered occupancy, so it never loops back on push valids.
  assign push_rdy = (count <= CNT_W'(DEPTH - 2));
  assign do_push0 = push_rdy && push0_vld;
  assign do_push1 = push_rdy && push1_vld;
  assign push_n   = {1'b0, do_push0} + {1'b0, do_push1};

  assign head     = queue_mem[rd_ptr];
  assign rf_re    = (count != '0) && !wb_we;
  assign rf_raddr = head.row;
  assign pop      = rf_re;

  assign bk_data  = rf_rdata;
  assign q_count  = count;

  // Port 1 lands behind port 0 when both push in the same cycle.
  always_ff @(posedge clk) begin
    if (do_push0)
      queue_mem[wr_ptr] <= '{ocid: push0_ocid, row: push0_row};
    if (do_push1)
      queue_mem[wr_ptr + PTR_W'(do_push0)] <= '{ocid: push1_ocid, row: push1_row};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // Return stage lines up with the SRAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bk_vld  <= 1'b0;
      bk_bz   <= 1'b0;
      bk_ocid <= '0;
    end else begin
      bk_vld <= rf_re;
      bk_bz  <= wb_we && (count != '0);
      if (rf_re)
        bk_ocid <= head.ocid;
    end
  end

endmodule

// File: tb/tb_oc_bank_read_scheduler.sv
// Bench for oc_bank_read_scheduler: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_oc_bank_read_scheduler;

  localparam int DEPTH  = 4;
  localparam int ROW_W  = 3;
  localparam int DATA_W = 256;
  localparam int OCID_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push0_vld, push1_vld;
  logic [OCID_W-1:0] push0_ocid, push1_ocid;
  logic [ROW_W-1:0]  push0_row, push1_row;
  logic              push_rdy;
  logic              wb_we;
  logic [ROW_W-1:0]  wb_row;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        wb_mask;
  logic              rf_we;
  logic [ROW_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [7:0]        rf_wmask;
  logic              rf_re;
  logic [ROW_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata = '0;
  logic [DATA_W-1:0] bk_data;
  logic [OCID_W-1:0] bk_ocid;
  logic              bk_vld;
  logic              bk_bz;
  logic [$clog2(DEPTH):0] q_count;

  int checks = 0;
  int errors = 0;

  oc_bank_read_scheduler #(.DEPTH(DEPTH), .ROW_W(ROW_W), .DATA_W(DATA_W), .OCID_W(OCID_W)) dut (
    .clk(clk), .rst(rst),
    .push0_vld(push0_vld), .push0_ocid(push0_ocid), .push0_row(push0_row),
    .push1_vld(push1_vld), .push1_ocid(push1_ocid), .push1_row(push1_row),
    .push_rdy(push_rdy),
    .wb_we(wb_we), .wb_row(wb_row), .wb_data(wb_data), .wb_mask(wb_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wmask(rf_wmask),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .bk_data(bk_data), .bk_ocid(bk_ocid), .bk_vld(bk_vld), .bk_bz(bk_bz),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rowData(input int r);
    return {8{32'hA5A5_0000 | 32'(r)}};
  endfunction

  // Bank SRAM seen by the DUT: write-first across cycles, one-cycle read.
  logic [DATA_W-1:0] sram [8];
  always @(posedge clk) begin
    if (rf_we)
      for (int l = 0; l < 8; l++)
        if (rf_wmask[l]) sram[rf_waddr][l*32 +: 32] <= rf_wdata[l*32 +: 32];
    if (rf_re)
      rf_rdata <= sram[rf_raddr];
  end

  // Reference model: a plain queue of requests and the bank contents as written.
  typedef struct {
    logic [OCID_W-1:0] ocid;
    logic [ROW_W-1:0]  row;
  } req_t;

  req_t              mq[$];
  logic [DATA_W-1:0] mmem [8];
  logic              exp_vld = 1'b0;
  logic              exp_bz = 1'b0;
  logic [OCID_W-1:0] exp_ocid = '0;
  logic [DATA_W-1:0] exp_data = '0;
  int                mdl_sz;
  int                cmp_sz;

  initial
    for (int r = 0; r < 8; r++) begin
      sram[r] = '0;
      mmem[r] = '0;
    end

  always @(posedge clk)
    if (wb_we)
      for (int l = 0; l < 8; l++)
        if (wb_mask[l]) mmem[wb_row][l*32 +: 32] = wb_data[l*32 +: 32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_vld  = 1'b0;
      exp_bz   = 1'b0;
      exp_ocid = '0;
    end else begin
      req_t r;
      mdl_sz  = mq.size();
      exp_vld = (mdl_sz != 0) && !wb_we;
      exp_bz  = wb_we && (mdl_sz != 0);
      if (exp_vld) begin
        r        = mq.pop_front();
        exp_ocid = r.ocid;
        exp_data = mmem[r.row];
      end
      if (mdl_sz <= DEPTH - 2) begin
        if (push0_vld) mq.push_back('{push0_ocid, push0_row});
        if (push1_vld) mq.push_back('{push1_ocid, push1_row});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rst_q_count", q_count, 0);
      checkOutput("rst_push_rdy", push_rdy, 1);
      checkOutput("rst_bk_vld", bk_vld, 0);
      checkOutput("rst_bk_bz", bk_bz, 0);
      checkOutput("rst_rf_re", rf_re, 0);
      checkOutput("rst_bk_ocid", bk_ocid, 0);
    end else begin
      cmp_sz = mq.size();
      checkOutput("q_count", q_count, cmp_sz);
      checkOutput("push_rdy", push_rdy, cmp_sz <= DEPTH - 2);
      checkOutput("rf_re", rf_re, (cmp_sz != 0) && !wb_we);
      if ((cmp_sz != 0) && !wb_we)
        checkOutput("rf_raddr", rf_raddr, mq[0].row);
      checkOutput("bk_vld", bk_vld, exp_vld);
      checkOutput("bk_bz", bk_bz, exp_bz);
      if (exp_vld) begin
        checkOutput("bk_ocid", bk_ocid, exp_ocid);
        checkOutput("bk_data", bk_data, exp_data);
      end
    end
    checkOutput("rf_we", rf_we, wb_we);
    if (wb_we) begin
      checkOutput("rf_waddr", rf_waddr, wb_row);
      checkOutput("rf_wdata", rf_wdata, wb_data);
      checkOutput("rf_wmask", rf_wmask, wb_mask);
    end
  end

  logic [OCID_W-1:0] ret_q[$];
  always @(negedge clk)
    if (rst && bk_vld) ret_q.push_back(bk_ocid);

  task automatic drive(input logic p0v, input logic [2:0] p0o, input logic [2:0] p0r,
                       input logic p1v, input logic [2:0] p1o, input logic [2:0] p1r,
                       input logic we, input logic [2:0] wr, input logic [DATA_W-1:0] wd,
                       input logic [7:0] wm);
    push0_vld = p0v; push0_ocid = p0o; push0_row = p0r;
    push1_vld = p1v; push1_ocid = p1o; push1_row = p1r;
    wb_we = we; wb_row = wr; wb_data = wd; wb_mask = wm;
  endtask

  task automatic applyStimulus(input logic p0v, input logic [2:0] p0o, input logic [2:0] p0r,
                               input logic p1v, input logic [2:0] p1o, input logic [2:0] p1r,
                               input logic we, input logic [2:0] wr,
                               input logic [DATA_W-1:0] wd, input logic [7:0] wm);
    @(posedge clk);
    #1;
    drive(p0v, p0o, p0r, p1v, p1o, p1r, we, wr, wd, wm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, '0, 8'h00);
  endtask

  logic [OCID_W-1:0] wrap_exp [10];
  int n_pushed;
  int cyc;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 8'h00);

    // Reset held with pushes and writeback activity.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 3'(i), 3'(i), 1, 3'(i + 1), 3'(i), i[0], 7, '1, 8'h00);
    @(negedge clk);
    checkOutput("lit_rst_q_count", q_count, 0);
    checkOutput("lit_rst_push_rdy", push_rdy, 1);
    idle(1);
    rst = 1'b1;
    idle(1);

    // Fill the bank with recognisable rows; writes to an empty queue never busy.
    for (int r = 0; r < 8; r++)
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'(r), rowData(r), 8'hFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, '1, 8'h0F);
    @(negedge clk);
    checkOutput("lit_idle_wb_bz", bk_bz, 0);
    idle(2);

    // Single read.
    applyStimulus(1, 3'b101, 2, 0, 0, 0, 0, 0, '0, 8'h00);
    idle(1);
    @(negedge clk);
    checkOutput("lit_single_rf_re", rf_re, 1);
    checkOutput("lit_single_raddr", rf_raddr, 2);
    idle(1);
    @(negedge clk);
    checkOutput("lit_single_vld", bk_vld, 1);
    checkOutput("lit_single_ocid", bk_ocid, 5);
    checkOutput("lit_single_data", bk_data, rowData(2));
    idle(2);

    // Dual push order.
    ret_q.delete();
    applyStimulus(1, 0, 1, 1, 1, 6, 0, 0, '0, 8'h00);
    idle(5);
    checkOutput("lit_dual_count", ret_q.size(), 2);
    checkOutput("lit_dual_first", ret_q[0], 0);
    checkOutput("lit_dual_second", ret_q[1], 1);

    // Writeback steals the port for two cycles.
    applyStimulus(1, 6, 4, 0, 0, 0, 0, 0, '0, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, {8{32'h1234_5678}}, 8'hFF);
    @(negedge clk);
    checkOutput("lit_steal_re0", rf_re, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, {8{32'h1234_5678}}, 8'hFF);
    @(negedge clk);
    checkOutput("lit_steal_bz1", bk_bz, 1);
    idle(1);
    @(negedge clk);
    checkOutput("lit_steal_bz2", bk_bz, 1);
    checkOutput("lit_steal_re1", rf_re, 1);
    idle(1);
    @(negedge clk);
    checkOutput("lit_steal_vld", bk_vld, 1);
    checkOutput("lit_steal_ocid", bk_ocid, 6);
    idle(2);

    // Write then read of the same row on the next cycle.
    applyStimulus(1, 2, 1, 0, 0, 0, 1, 1, {8{32'hCAFE_0001}}, 8'hFF);
    idle(1);
    idle(1);
    @(negedge clk);
    checkOutput("lit_wf_vld", bk_vld, 1);
    checkOutput("lit_wf_data", bk_data, {8{32'hCAFE_0001}});
    idle(2);

    // Fill to capacity under a held writeback, then drain across the pointer wrap.
    ret_q.delete();
    for (int i = 0; i < 10; i++) wrap_exp[i] = 3'(i % 8);
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 7, '0, 8'h00);
    applyStimulus(1, 2, 2, 1, 3, 3, 1, 7, '0, 8'h00);
    applyStimulus(1, 7, 7, 1, 7, 7, 1, 7, '0, 8'h00);
    @(negedge clk);
    checkOutput("lit_full_rdy", push_rdy, 0);
    checkOutput("lit_full_count", q_count, 4);
    @(posedge clk);
    #1;
    n_pushed = 4;
    cyc = 0;
    while (n_pushed < 10 && cyc < 40) begin
      if (push_rdy) begin
        drive(1, 3'(n_pushed % 8), 3'(n_pushed % 8), 1, 3'((n_pushed + 1) % 8),
              3'((n_pushed + 1) % 8), 0, 0, '0, 8'h00);
        n_pushed += 2;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 8'h00);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    if (n_pushed < 10) checkOutput("wrap_push_timeout", n_pushed, 10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 8'h00);
    idle(12);
    checkOutput("lit_wrap_count", ret_q.size(), 10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("lit_wrap_tag%0d", i), ret_q[i], wrap_exp[i]);

    // Asynchronous reset between issue and return.
    applyStimulus(1, 3, 5, 0, 0, 0, 0, 0, '0, 8'h00);
    idle(1);
    @(negedge clk);
    checkOutput("lit_ar_re", rf_re, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("lit_ar_count", q_count, 0);
    checkOutput("lit_ar_vld", bk_vld, 0);
    checkOutput("lit_ar_re0", rf_re, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge clk);
      checkOutput("lit_ar_no_vld", bk_vld, 0);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
